// File: rtl/fabric_pkg.sv
// Shared types and constants for the fabric round-robin arbiter.
package fabric_pkg;

  localparam int FAB_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first requester at or above ptr, wrapping mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int          c;
  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx  = '0;
    any  = 1'b0;
    c    = 0;
    cand = '0;
    // Walk offsets from farthest to nearest so the closest requester to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      cand = IW'(c);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fabric_rr_arbiter.sv
// Round-robin arbiter sequencing one read/write at a time from N masters onto a single
// fabric port, returning completion, read data and timeout error to the granted master.
module fabric_rr_arbiter
  import fabric_pkg::*;
#(
  parameter int N_MST   = 4,
  parameter int WIDTH   = FAB_WIDTH,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MST-1:0]       m_req,
  input  logic [N_MST-1:0]       m_we,
  input  logic [N_MST*WIDTH-1:0] m_wdata,
  output logic [N_MST-1:0]       m_gnt,
  output logic [N_MST-1:0]       m_rvalid,
  output logic                   m_err,
  output logic [WIDTH-1:0]       m_rdata,
  output logic                   fab_read_req,
  output logic                   fab_write_req,
  output logic [WIDTH-1:0]       fab_write_data,
  input  logic [WIDTH-1:0]       fab_read_data,
  input  logic                   fab_resp_valid
);

  localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx;
  logic             we_q;
  logic [TW-1:0]    timer;
  logic [TW-1:0]    timer_nxt;

  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] pick_wdata;
  logic [N_MST-1:0] pick_oh;
  logic [N_MST-1:0] idx_oh;

  rr_pick #(.N(N_MST), .IW(IW)) u_pick (
    .req (m_req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_wdata = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (pick_idx == IW'(i)) pick_wdata = m_wdata[i*WIDTH +: WIDTH];
    end
  end

  assign pick_oh   = N_MST'(1) << pick_idx;
  assign idx_oh    = N_MST'(1) << idx;
  assign timer_nxt = timer + TW'(1);

  // NOTE: all state and output registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      idx            <= '0;
      we_q           <= 1'b0;
      timer          <= '0;
      m_gnt          <= '0;
      m_rvalid       <= '0;
      m_err          <= 1'b0;
      m_rdata        <= '0;
      fab_read_req   <= 1'b0;
      fab_write_req  <= 1'b0;
      fab_write_data <= '0;
    end else begin
      // Pulses default low; only the state being entered raises them for one cycle.
      m_gnt         <= '0;
      m_rvalid      <= '0;
      fab_read_req  <= 1'b0;
      fab_write_req <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (pick_any) begin
            idx            <= pick_idx;
            we_q           <= m_we[pick_idx];
            fab_write_data <= pick_wdata;
            fab_write_req  <= m_we[pick_idx];
            fab_read_req   <= ~m_we[pick_idx];
            m_gnt          <= pick_oh;
            state          <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          ptr   <= (idx == IW'(N_MST - 1)) ? '0 : idx + 1'b1;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (fab_resp_valid) begin
            m_rdata  <= we_q ? '0 : fab_read_data;
            m_err    <= 1'b0;
            m_rvalid <= idx_oh;
            state    <= RESP;
          end else begin
            timer <= timer_nxt;
            // Give up after TIMEOUT cycles in WAIT.
            if (timer_nxt == TW'(TIMEOUT)) begin
              m_rdata  <= '0;
              m_err    <= 1'b1;
              m_rvalid <= idx_oh;
              state    <= RESP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
